// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard receive path: frame states,
// default bus addresses and status word layout.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam logic [13:0] KBD_ADDRESS_DEF    = 14'h3FFF;
  localparam logic [13:0] STATUS_ADDRESS_DEF = 14'h3FFE;

  localparam int FRAME_ERR_BIT = 0;
  localparam int OVERFLOW_BIT  = 1;
  localparam int FULL_BIT      = 2;
  localparam int COUNT_LSB     = 8;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] byte_in, input logic par_in);
    return ^{byte_in, par_in};
  endfunction

endpackage

// File: rtl/kbd_scancode_fifo.sv
// Synchronous scancode FIFO. A push on a full FIFO is accepted only when a pop
// frees a slot in the same cycle; otherwise it is dropped here and flagged by the caller.
module kbd_scancode_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_srst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [$clog2(DEPTH):0]     o_count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_next;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_next = r_count + (AW+1)'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_count_next = r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
    end
  end

  assign o_head       = r_mem[r_rd_ptr];
  assign o_full       = (r_count == FULL_CNT);
  assign o_empty      = (r_count == '0);
  assign o_count      = r_count;
  assign o_count_next = w_count_next;

endmodule

// File: rtl/ps2_frame_controller.sv
// PS/2 keyboard receiver: synchronizes the pins, frames 11-bit packets, queues
// good scancodes and serves them plus a status word on the memory-mapped bus.
module ps2_frame_controller
  import kbd_pkg::*;
#(
  parameter logic [13:0] KBD_ADDRESS    = KBD_ADDRESS_DEF,
  parameter logic [13:0] STATUS_ADDRESS = STATUS_ADDRESS_DEF,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          TIMEOUT_CYCLES = 2000
) (
  input  logic        system_clk,
  input  logic        reset,
  input  logic [13:0] address,
  input  logic        read_en,
  input  logic        PS2_clk,
  input  logic        PS2_data,
  output logic [63:0] data,
  output logic        irq
);

  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Pin synchronizers; bit 0 = PS2_clk, bit 1 = PS2_data. Idle-high reset
  // value keeps a reset release from looking like a falling edge.
  logic [1:0] r_pin_meta;
  logic [1:0] r_pin_sync;
  logic       r_clk_prev;
  logic       w_fall;
  logic       w_data_bit;

  frame_state_t r_state;
  frame_state_t w_state_next;

  logic [7:0]      r_shreg;
  logic [2:0]      r_bit_cnt;
  logic            r_parity_ok;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_timeout;
  logic            w_push;
  logic            w_frame_err_set;

  logic            r_frame_err;
  logic            r_overflow;
  logic [63:0]     r_data;
  logic            r_irq;

  logic            w_kbd_rd;
  logic            w_status_rd;
  logic            w_pop;
  logic            w_overflow_set;
  logic [63:0]     w_status;

  logic [7:0]      w_fifo_head;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [CW-1:0]   w_fifo_count;
  logic [CW-1:0]   w_fifo_count_next;

  always_ff @(posedge system_clk) begin
    if (reset) begin
      r_pin_meta <= 2'b11;
      r_pin_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_pin_meta <= {PS2_data, PS2_clk};
      r_pin_sync <= r_pin_meta;
      r_clk_prev <= r_pin_sync[0];
    end
  end

  assign w_fall     = r_clk_prev && !r_pin_sync[0];
  assign w_data_bit = r_pin_sync[1];

  always_ff @(posedge system_clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_push          = 1'b0;
    w_frame_err_set = 1'b0;
    w_timeout       = (r_state != IDLE) && (r_to_cnt == TO_LAST);
    if (w_timeout) begin
      w_state_next    = IDLE;
      w_frame_err_set = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        IDLE: begin
          if (!w_data_bit) begin
            w_state_next = DATA;
          end
        end
        DATA: begin
          if (r_bit_cnt == 3'd7) begin
            w_state_next = PARITY;
          end
        end
        PARITY: begin
          w_state_next = STOP;
        end
        STOP: begin
          w_state_next = IDLE;
          if (r_parity_ok && w_data_bit) begin
            w_push = 1'b1;
          end else begin
            w_frame_err_set = 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // Frame datapath: shift register, bit counter, parity latch and the
  // inactivity counter that restarts on every keyboard clock falling edge.
  always_ff @(posedge system_clk) begin
    if (reset) begin
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_parity_ok <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      if ((r_state == IDLE) || w_fall || w_timeout) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_fall && !w_timeout) begin
        case (r_state)
          IDLE: begin
            r_bit_cnt <= '0;
          end
          DATA: begin
            r_shreg   <= {w_data_bit, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY: begin
            r_parity_ok <= odd_parity_ok(r_shreg, w_data_bit);
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign w_kbd_rd       = read_en && (address == KBD_ADDRESS);
  assign w_status_rd    = read_en && (address == STATUS_ADDRESS);
  assign w_pop          = w_kbd_rd && !w_fifo_empty;
  assign w_overflow_set = w_push && w_fifo_full && !w_pop;

  kbd_scancode_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk        (system_clk),
    .i_srst       (reset),
    .i_push       (w_push),
    .i_din        (r_shreg),
    .i_pop        (w_pop),
    .o_head       (w_fifo_head),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty),
    .o_count      (w_fifo_count),
    .o_count_next (w_fifo_count_next)
  );

  always_comb begin
    w_status                    = '0;
    w_status[COUNT_LSB +: 8]    = 8'(w_fifo_count);
    w_status[FULL_BIT]          = w_fifo_full;
    w_status[OVERFLOW_BIT]      = r_overflow;
    w_status[FRAME_ERR_BIT]     = r_frame_err;
  end

  // A status read clears the sticky flags, but an error raised on the same
  // edge is OR-ed in afterwards so it is never lost.
  always_ff @(posedge system_clk) begin
    if (reset) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_data      <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_frame_err <= (r_frame_err && !w_status_rd) || w_frame_err_set;
      r_overflow  <= (r_overflow && !w_status_rd) || w_overflow_set;
      r_irq       <= (w_fifo_count_next != '0);
      if (w_kbd_rd) begin
        if (w_fifo_empty) begin
          r_data <= '0;
        end else begin
          r_data <= {55'b0, 1'b1, w_fifo_head};
        end
      end else if (w_status_rd) begin
        r_data <= w_status;
      end
    end
  end

  assign data = r_data;
  assign irq  = r_irq;

endmodule

// File: tb/tb_ps2_frame_controller.sv
// Self-checking bench for ps2_frame_controller: a queue-based model of the
// scancode buffer and sticky flags, plus literal expectations for key reads.
module tb_ps2_frame_controller;

  localparam logic [13:0] KBD = 14'h3FFF;
  localparam logic [13:0] STA = 14'h3FFE;
  localparam int          H   = 4;

  logic        system_clk = 1'b0;
  logic        reset      = 1'b1;
  logic [13:0] address    = '0;
  logic        read_en    = 1'b0;
  logic        PS2_clk    = 1'b1;
  logic        PS2_data   = 1'b1;
  logic [63:0] data;
  logic        irq;

  always #5 system_clk = ~system_clk;

  ps2_frame_controller dut (
    .system_clk (system_clk),
    .reset      (reset),
    .address    (address),
    .read_en    (read_en),
    .PS2_clk    (PS2_clk),
    .PS2_data   (PS2_data),
    .data       (data),
    .irq        (irq)
  );

  // Model state
  logic [7:0]  mq[$];
  logic        m_ovf  = 1'b0;
  logic        m_ferr = 1'b0;
  logic [63:0] m_data = '0;
  bit          chk_en  = 1'b0;
  bit          chk_irq = 1'b1;

  // Literal-expectation requests handed to the compare process
  int          lit_seq  = 0;
  int          lit_seen = 0;
  int          lit_kind = 0;
  logic [63:0] lit_exp  = '0;
  string       lit_name = "";

  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge system_clk) begin
    logic [63:0] act;
    #1;
    if (chk_en) begin
      n_cmp++;
      if (data !== m_data) begin
        n_bad++;
        $display("FAIL data_track t=%0t actual=%h required=%h", $time, data, m_data);
      end
      if (chk_irq) begin
        n_cmp++;
        if (irq !== (mq.size() != 0)) begin
          n_bad++;
          $display("FAIL irq_track t=%0t actual=%b required=%b", $time, irq, (mq.size() != 0));
        end
      end
    end
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      act = (lit_kind == 0) ? data : {63'b0, irq};
      n_cmp++;
      if (act !== lit_exp) begin
        n_bad++;
        $display("FAIL %s actual=%h required=%h", lit_name, act, lit_exp);
      end
    end
  end

  task automatic tick();
    @(negedge system_clk);
  endtask

  task automatic lit_check(input int kind, input logic [63:0] exp, input string name);
    lit_kind = kind;
    lit_exp  = exp;
    lit_name = name;
    lit_seq++;
    tick();
  endtask

  task automatic model_push(input logic [7:0] b);
    if (mq.size() == 8) m_ovf = 1'b1;
    else mq.push_back(b);
  endtask

  task automatic bus_read(input logic [13:0] addr);
    read_en = 1'b1;
    address = addr;
    if (addr == KBD) begin
      if (mq.size() > 0) m_data = {55'b0, 1'b1, mq.pop_front()};
      else m_data = '0;
    end else if (addr == STA) begin
      m_data = {48'b0, 8'(mq.size()), 5'b0, (mq.size() == 8), m_ovf, m_ferr};
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
    end
    tick();
    read_en = 1'b0;
  endtask

  task automatic read_chk(input logic [13:0] addr, input logic [63:0] exp, input string name);
    bus_read(addr);
    lit_check(0, exp, name);
  endtask

  task automatic drive_bit(input logic b);
    PS2_data = b;
    repeat (H) tick();
    PS2_clk = 1'b0;
    repeat (H) tick();
    PS2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input bit pop_at_stop);
    bit good;
    good = (^{b, par}) && stp;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    PS2_data = stp;
    repeat (H) tick();
    if (pop_at_stop) begin
      // The stop edge is seen three clocks after the pin falls; read on that edge.
      PS2_clk = 1'b0;
      repeat (2) tick();
      bus_read(KBD);
      if (good) model_push(b); else m_ferr = 1'b1;
      repeat (H - 3) tick();
    end else begin
      chk_irq = 1'b0;
      PS2_clk = 1'b0;
      repeat (H) tick();
      if (good) model_push(b); else m_ferr = 1'b1;
      chk_irq = 1'b1;
    end
    PS2_clk = 1'b1;
    repeat (H) tick();
    PS2_data = 1'b1;
    repeat (H) tick();
  endtask

  task automatic send_good(input logic [7:0] b, input bit pop_at_stop);
    send_frame(b, ~^b, 1'b1, pop_at_stop);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;
    repeat (3) tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    tick();

    // Reset state
    lit_check(0, 64'h0, "reset_data");
    lit_check(1, 64'h0, "reset_irq");
    read_chk(STA, 64'h0, "reset_status");
    read_chk(KBD, 64'h0, "empty_pop");

    // 1: single good frame
    send_good(8'h48, 1'b0);
    lit_check(1, 64'h1, "t1_irq_before");
    read_chk(KBD, 64'h148, "t1_pop");
    lit_check(1, 64'h0, "t1_irq_after");
    bus_read(14'h0100);
    lit_check(0, 64'h148, "t1_other_addr_hold");

    // 2: bad parity
    send_frame(8'h6C, 1'b0, 1'b1, 1'b0);
    lit_check(1, 64'h0, "t2_no_push");
    read_chk(STA, 64'h1, "t2_status_err");
    read_chk(STA, 64'h0, "t2_status_cleared");

    // 3: overflow
    for (int i = 0; i < 9; i++) send_good(8'(i), 1'b0);
    read_chk(STA, 64'h0806, "t3_status_full_ovf");
    for (int i = 0; i < 8; i++) begin
      e = {55'b0, 1'b1, 8'(i)};
      read_chk(KBD, e, "t3_pop");
    end

    // 4: pop coincident with stop-edge push on a full FIFO
    for (int i = 0; i < 8; i++) send_good(8'(8'h10 + i), 1'b0);
    send_good(8'h18, 1'b1);
    lit_check(0, 64'h110, "t4_coincident_pop");
    read_chk(STA, 64'h0804, "t4_status_no_ovf");
    for (int i = 1; i < 9; i++) begin
      e = {55'b0, 1'b1, 8'(8'h10 + i)};
      read_chk(KBD, e, "t4_pop");
    end

    // 5: timeout mid-frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (2100) tick();
    m_ferr = 1'b1;
    read_chk(STA, 64'h1, "t5_timeout_err");
    send_good(8'h21, 1'b0);
    read_chk(KBD, 64'h121, "t5_after_timeout");

    // 6: reset mid-frame with entries queued
    send_good(8'h30, 1'b0);
    send_good(8'h31, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    reset = 1'b1;
    mq.delete();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    m_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    lit_check(0, 64'h0, "t6_data");
    lit_check(1, 64'h0, "t6_irq");
    read_chk(STA, 64'h0, "t6_status");
    send_good(8'h57, 1'b0);
    read_chk(KBD, 64'h157, "t6_after_reset");

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
